// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : Memory-access stage and MEM/WB pipeline register. LDR/STR are
//             issued on a req/ack data-memory port. The upstream pipeline is
//             stalled while an access is outstanding. The block drives the
//             register-file write port.
//  Ports    : clk, rst                      - clock, async active-high reset
//             mem_r_en, mem_w_en            - load / store in MEM
//             wb_en_in, dest_in             - register writeback request
//             alu_res, st_val               - address/value, store data
//             freeze                        - upstream stall (combinational)
//             mem_req/we/addr/wdata         - memory request side
//             mem_rdata, mem_ack            - memory response side
//             wb_en, wb_dest, wb_value      - register-file write port
//             mem_err                       - sticky access-timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int BASE_ADDR = 1024,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en_in,
    input  logic [3:0]        dest_in,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       st_val,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_en,
    output logic [3:0]        wb_dest,
    output logic [31:0]       wb_value,
    output logic              mem_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // Counter value seen in the last BUSY cycle allowed before abort, so the
    // access is abandoned after exactly TIMEOUT un-acked BUSY cycles.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [0:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_hold_wb_en;
    logic [3:0]        r_hold_dest;

    logic              w_memop;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addr;

    assign w_memop   = mem_r_en | mem_w_en;
    assign w_timeout = (r_cnt == c_TO_LAST);

    // Subtraction wraps modulo 2^32; low-memory addresses alias silently.
    assign w_addr = ADDR_W'((alu_res - 32'(BASE_ADDR)) >> 2);

    // Nothing needs to stall while the stage is held in reset.
    assign freeze = ~rst & (((r_state == S_IDLE) & w_memop) |
                            ((r_state == S_BUSY) & ~mem_ack));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_hold_wb_en <= 1'b0;
            r_hold_dest  <= 4'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            wb_en        <= 1'b0;
            wb_dest      <= 4'd0;
            wb_value     <= 32'd0;
            mem_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop) begin
                        mem_addr     <= w_addr;
                        mem_wdata    <= st_val;
                        mem_we       <= mem_w_en & ~mem_r_en;
                        r_hold_wb_en <= wb_en_in;
                        r_hold_dest  <= dest_in;
                        mem_req      <= 1'b1;
                        r_cnt        <= 8'd0;
                        wb_en        <= 1'b0;
                        r_state      <= S_BUSY;
                    end else begin
                        wb_en    <= wb_en_in;
                        wb_dest  <= dest_in;
                        wb_value <= alu_res;
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                        if (mem_we) begin
                            wb_en <= 1'b0;
                        end else begin
                            wb_en    <= r_hold_wb_en;
                            wb_dest  <= r_hold_dest;
                            wb_value <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        wb_en   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Self-checking bench for mem_wb_stage (BASE_ADDR=1024,
//             ADDR_W=16, TIMEOUT=4). Directed table, hand sequences for
//             reset/idle-ack corner cases, and randomized instructions
//             checked against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int c_BASE = 1024;
    localparam int c_AW   = 16;
    localparam int c_TO   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_r_en, mem_w_en, wb_en_in;
    logic [3:0]        dest_in;
    logic [31:0]       alu_res, st_val;
    logic              freeze, mem_req, mem_we;
    logic [c_AW-1:0]   mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_ack;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [31:0]       wb_value;
    logic              mem_err;

    mem_wb_stage #(.BASE_ADDR(c_BASE), .ADDR_W(c_AW), .TIMEOUT(c_TO)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_in(wb_en_in),
        .dest_in(dest_in), .alu_res(alu_res), .st_val(st_val),
        .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // ackd: index of the BUSY cycle carrying the ack; -1 means never.
    typedef struct {
        bit        rd, wr, wben;
        bit [3:0]  dest;
        bit [31:0] alu, st, rdata;
        int        ackd;
        bit [15:0] exp_addr;
        bit        exp_we;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the register-file port should show.
    bit        m_wb_en;
    bit [3:0]  m_dest;
    bit [31:0] m_val;
    bit        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wb(input string tag);
        chk({tag, ".wb_en"},    wb_en,    m_wb_en);
        chk({tag, ".wb_dest"},  wb_dest,  m_dest);
        chk({tag, ".wb_value"}, wb_value, m_val);
        chk({tag, ".mem_err"},  mem_err,  m_err);
    endtask

    // Word address by plain arithmetic on a 64-bit value: wrap, divide, truncate.
    function automatic bit [15:0] model_addr(input bit [31:0] a);
        longint unsigned t;
        t = (longint'(a) + 64'h1_0000_0000 - c_BASE) % 64'h1_0000_0000;
        return 16'((t / 4) % 65536);
    endfunction

    // Presents one instruction starting at posedge+1 with the DUT in IDLE,
    // answers the memory port per v.ackd, and checks every observable step.
    task automatic run_instr(input vec_t v);
        bit memop;
        memop    = v.rd | v.wr;
        mem_r_en = v.rd;  mem_w_en = v.wr;  wb_en_in = v.wben;
        dest_in  = v.dest; alu_res = v.alu; st_val   = v.st;
        mem_ack  = 1'b0;
        #1;
        chk("freeze_issue", freeze, memop);
        @(posedge clk); #1;
        if (!memop) begin
            m_wb_en = v.wben; m_dest = v.dest; m_val = v.alu;
            chk_wb("alu");
            chk("alu.mem_req", mem_req, 1'b0);
            return;
        end
        chk("busy.mem_req",   mem_req,   1'b1);
        chk("busy.mem_we",    mem_we,    v.exp_we);
        chk("busy.mem_addr",  mem_addr,  v.exp_addr);
        chk("busy.mem_wdata", mem_wdata, v.st);
        m_wb_en = 1'b0;
        chk_wb("bubble");
        for (int k = 0; k < c_TO; k++) begin
            if (k == v.ackd) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
                #1;
                chk("ack.freeze", freeze, 1'b0);
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
                chk("ack.mem_req", mem_req, 1'b0);
                if (v.exp_we) begin
                    m_wb_en = 1'b0;
                end else begin
                    m_wb_en = v.wben; m_dest = v.dest; m_val = v.rdata;
                end
                chk_wb("ack");
                return;
            end
            #1;
            chk("wait.freeze",   freeze,   1'b1);
            chk("wait.mem_req",  mem_req,  1'b1);
            chk("wait.mem_addr", mem_addr, v.exp_addr);
            @(posedge clk); #1;
        end
        m_err = 1'b1; m_wb_en = 1'b0;
        chk("timeout.mem_req", mem_req, 1'b0);
        chk_wb("timeout");
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //            rd wr wb dest alu           st            rdata         ackd addr     we
        tbl[0] = '{0, 0, 1, 4'd3,  32'h55,       32'h0,        32'h0,        0,   16'h0,   0};
        tbl[1] = '{1, 0, 1, 4'd5,  32'd1032,     32'h0,        32'hDEADBEEF, 2,   16'd2,   0};
        tbl[2] = '{0, 1, 0, 4'd6,  32'd1028,     32'h1234,     32'h0,        0,   16'd1,   1};
        tbl[3] = '{1, 0, 1, 4'd7,  32'h0,        32'h0,        32'hA5A50001, 1,   16'hFF00, 0};
        tbl[4] = '{1, 1, 1, 4'd9,  32'h00050404, 32'hFFFF0000, 32'h11112222, 0,   16'h4001, 0};
        tbl[5] = '{1, 0, 1, 4'd2,  32'd1088,     32'h0,        32'h0BADF00D, 3,   16'd16,  0};
        tbl[6] = '{1, 0, 1, 4'd4,  32'd1040,     32'h0,        32'h0,        -1,  16'd4,   0};
        tbl[7] = '{0, 0, 1, 4'd12, 32'hCAFEF00D, 32'h0,        32'h0,        0,   16'h0,   0};
        tbl[8] = '{0, 1, 1, 4'd8,  32'd2048,     32'h77,       32'h0,        1,   16'h100, 1};

        rst = 1'b1; mem_r_en = 0; mem_w_en = 0; wb_en_in = 0; dest_in = 0;
        alu_res = 0; st_val = 0; mem_rdata = 0; mem_ack = 0;
        m_wb_en = 0; m_dest = 0; m_val = 0; m_err = 0;
        #2;
        chk("rst.mem_req",   mem_req,   1'b0);
        chk("rst.mem_we",    mem_we,    1'b0);
        chk("rst.mem_addr",  mem_addr,  16'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.freeze",    freeze,    1'b0);
        chk_wb("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) run_instr(tbl[i]);

        // Spurious ack while IDLE must neither start nor complete anything.
        mem_r_en = 0; mem_w_en = 0; wb_en_in = 0; dest_in = 4'd1; alu_res = 32'h31;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        m_wb_en = 0; m_dest = 4'd1; m_val = 32'h31;
        chk_wb("idle_ack");
        chk("idle_ack.mem_req", mem_req, 1'b0);

        // Back-to-back LDR then ALU op, both acked in the first BUSY cycle.
        run_instr('{1, 0, 1, 4'd10, 32'd1100, 32'h0, 32'h600DCAFE, 0, model_addr(32'd1100), 0});
        run_instr('{0, 0, 1, 4'd11, 32'h13579BDF, 32'h0, 32'h0, 0, 16'h0, 0});

        // Randomized traffic checked against the model.
        for (int n = 0; n < 60; n++) begin
            rv.rd    = ($urandom_range(0, 2) != 0);
            rv.wr    = ($urandom_range(0, 2) == 0);
            rv.wben  = $urandom_range(0, 1);
            rv.dest  = 4'($urandom);
            rv.alu   = ($urandom_range(0, 1) != 0) ? (32'd1024 + 32'($urandom_range(0, 4095))) : $urandom;
            rv.st    = $urandom;
            rv.rdata = $urandom;
            rv.ackd  = int'($urandom_range(0, 5)) - 1;
            rv.exp_addr = model_addr(rv.alu);
            rv.exp_we   = rv.wr & ~rv.rd;
            run_instr(rv);
        end

        // Make sure mem_err is set, then reset in the middle of a BUSY access.
        run_instr('{1, 0, 1, 4'd4, 32'd1040, 32'h0, 32'h0, -1, 16'd4, 0});
        mem_r_en = 1; mem_w_en = 0; wb_en_in = 1; dest_in = 4'd14; alu_res = 32'd1200;
        @(posedge clk); #1;
        chk("pre_rst.mem_req", mem_req, 1'b1);
        rst = 1'b1; mem_r_en = 0;
        #1;
        m_wb_en = 0; m_dest = 0; m_val = 0; m_err = 0;
        chk("mid_rst.mem_req", mem_req, 1'b0);
        chk("mid_rst.freeze",  freeze,  1'b0);
        chk_wb("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0; wb_en_in = 0; dest_in = 0; alu_res = 0;
        mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("post_rst_ack.mem_req", mem_req, 1'b0);
        chk_wb("post_rst_ack");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
